// File: rtl/bus_pkg.sv
// Shared types and defaults for the burst master slice.
// Holds the FSM state encoding, the default BEATS / DATA_W / TIMEOUT values,
// and the helper that sizes the beat counter ($clog2(n+1)).
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    localparam int BEATS_DEF   = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 4;

    // Width that can hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int BEAT_CNT_W_DEF = cnt_width(BEATS_DEF);

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-cycle counter used to bound how long a beat may stall.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - clear the count (takes priority over en)
//   en        - count this cycle
//   limit     - count value that constitutes a timeout
//   expired   - high in the counted cycle whose increment reaches limit
module bus_timeout_ctr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_inc;

    always_comb begin
        cnt_inc = cnt_q + W'(1);
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != limit)) begin
            cnt_d = cnt_inc;
        end
    end

    // Flag fires as the count is reaching the limit, so the owner can drop
    // valid on the very next edge.
    assign expired = en && !clr && (cnt_inc == limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_burst_master.sv
// Burst initiator: on an accepted start, offers BEATS data beats
// (base, base+1, ...) under a valid/ready handshake, then pulses done.
// A beat stalled for TIMEOUT cycles aborts the burst and done comes with err.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start, base  - burst request and first data value (sampled when idle)
//   busy         - from cycle after accepted start through the done cycle
//   valid, data  - beat offer and payload
//   ready        - target acceptance
//   done, err    - one-cycle completion pulse, err on abort
// Build option: define BUS_BURST_STRICT_EN to abort on any ready=0 after the
// first handshake of a burst.
module bus_burst_master
    import bus_pkg::*;
#(
    parameter int BEATS   = BEATS_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] base,
    output logic              busy,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              done,
    output logic              err
);

    localparam int BEAT_W = cnt_width(BEATS);
    localparam int WAIT_W = cnt_width(TIMEOUT);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q,  beat_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic                valid_q, valid_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic                err_q,   err_d;

    logic                wait_clr;
    logic                wait_en;
    logic                wait_expired;
    logic [WAIT_W-1:0]   wait_limit;

    always_comb begin
`ifdef BUS_BURST_STRICT_EN
        // Once the first beat is taken, a single stall cycle is fatal.
        wait_limit = (beat_q != '0) ? WAIT_W'(1) : WAIT_W'(TIMEOUT);
`else
        wait_limit = WAIT_W'(TIMEOUT);
`endif
    end

    bus_timeout_ctr #(
        .W (WAIT_W)
    ) u_wait_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_clr),
        .en      (wait_en),
        .limit   (wait_limit),
        .expired (wait_expired)
    );

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wait_clr = 1'b1;
        wait_en  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = XFER;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    data_d  = base;
                    beat_d  = '0;
                end
            end
            XFER: begin
                if (!valid_q) begin
                    // valid only drops inside XFER on a timeout abort; this
                    // is the cycle after it, so report the failed burst.
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        data_d = data_q + DATA_W'(1);
                    end
                end else begin
                    wait_clr = 1'b0;
                    wait_en  = 1'b1;
                    if (wait_expired) begin
                        valid_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign data  = data_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bus_burst_master.sv
// Directed bench for bus_burst_master (BEATS=4, TIMEOUT=4, DATA_W=32).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bus_burst_master;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] base;
    logic          busy;
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_burst_master #(
        .BEATS   (4),
        .DATA_W  (DW),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .base  (base),
        .busy  (busy),
        .valid (valid),
        .ready (ready),
        .data  (data),
        .done  (done),
        .err   (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stall-free burst from an idle DUT, checked beat by beat.
    task automatic clean_burst(input logic [31:0] b, input string tag);
        ready = 1'b1;
        start = 1'b1;
        base  = b;
        step();
        start = 1'b0;
        base  = 32'hdead_beef;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_valid%0d", tag, i), {31'b0, valid}, 32'd1);
            check($sformatf("%s_data%0d", tag, i), data, b + 32'(i));
            check($sformatf("%s_busy%0d", tag, i), {31'b0, busy}, 32'd1);
            check($sformatf("%s_nodone%0d", tag, i), {31'b0, done}, 32'd0);
            step();
        end
        check({tag, "_end_valid"}, {31'b0, valid}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
        step();
        check({tag, "_done_once"}, {31'b0, done}, 32'd0);
        check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_data [6];
        logic        rdy_vec  [6];
        int          hs;

        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        base  = '0;
        step();
        step();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_data", data, 32'd0);
        rst = 1'b0;

        // 1: clean burst
        clean_burst(32'h10, "t1");

`ifndef BUS_BURST_STRICT_EN
        // 2: two-cycle stall on the second beat
        exp_data = '{32'h10, 32'h11, 32'h11, 32'h11, 32'h12, 32'h13};
        rdy_vec  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        hs = 0;
        ready = 1'b1;
        start = 1'b1;
        base  = 32'h10;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ready = rdy_vec[i];
            check($sformatf("t2_valid%0d", i), {31'b0, valid}, 32'd1);
            check($sformatf("t2_data%0d", i), data, exp_data[i]);
            if (valid && ready) hs++;
            step();
        end
        check("t2_done", {31'b0, done}, 32'd1);
        check("t2_err", {31'b0, err}, 32'd0);
        check("t2_valid_end", {31'b0, valid}, 32'd0);
        check("t2_beats", 32'(hs), 32'd4);
        step();
`endif

        // 3: ready never arrives -> timeout abort
        ready = 1'b0;
        start = 1'b1;
        base  = 32'h30;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_valid%0d", i), {31'b0, valid}, 32'd1);
            check($sformatf("t3_data%0d", i), data, 32'h30);
            check($sformatf("t3_nodone%0d", i), {31'b0, done}, 32'd0);
            step();
        end
        check("t3_valid_drop", {31'b0, valid}, 32'd0);
        check("t3_done_c5", {31'b0, done}, 32'd0);
        check("t3_busy_c5", {31'b0, busy}, 32'd1);
        step();
        check("t3_done", {31'b0, done}, 32'd1);
        check("t3_err", {31'b0, err}, 32'd1);
        check("t3_busy_c6", {31'b0, busy}, 32'd1);
        step();
        check("t3_done_once", {31'b0, done}, 32'd0);
        check("t3_err_once", {31'b0, err}, 32'd0);
        check("t3_idle_busy", {31'b0, busy}, 32'd0);
        ready = 1'b1;

        // 4: starts during XFER and during DONE are ignored
        start = 1'b1;
        base  = 32'h40;
        step();
        start = 1'b0;
        check("t4_data0", data, 32'h40);
        step();
        start = 1'b1;
        base  = 32'h99;
        check("t4_data1", data, 32'h41);
        step();
        start = 1'b0;
        check("t4_data2", data, 32'h42);
        step();
        check("t4_data3", data, 32'h43);
        step();
        check("t4_done", {31'b0, done}, 32'd1);
        start = 1'b1;
        base  = 32'h77;
        step();
        start = 1'b0;
        check("t4_no_restart_valid", {31'b0, valid}, 32'd0);
        check("t4_no_restart_busy", {31'b0, busy}, 32'd0);
        clean_burst(32'h50, "t4b");

        // 5: reset in the middle of a burst
        start = 1'b1;
        base  = 32'h60;
        step();
        start = 1'b0;
        step();
        step();
        check("t5_data_beat3", data, 32'h62);
        check("t5_valid_beat3", {31'b0, valid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_valid", {31'b0, valid}, 32'd0);
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_data", data, 32'd0);
        check("t5_done", {31'b0, done}, 32'd0);
        step();
        check("t5_no_done", {31'b0, done}, 32'd0);
        clean_burst(32'h60, "t5b");

`ifdef BUS_BURST_STRICT_EN
        // 6: strict mode, ready drops after the first beat
        ready = 1'b1;
        start = 1'b1;
        base  = 32'h70;
        step();
        start = 1'b0;
        check("t6_data0", data, 32'h70);
        step();
        ready = 1'b0;
        check("t6_valid1", {31'b0, valid}, 32'd1);
        check("t6_data1", data, 32'h71);
        step();
        check("t6_valid_drop", {31'b0, valid}, 32'd0);
        check("t6_nodone", {31'b0, done}, 32'd0);
        step();
        check("t6_done", {31'b0, done}, 32'd1);
        check("t6_err", {31'b0, err}, 32'd1);
        step();
        check("t6_done_once", {31'b0, done}, 32'd0);
        ready = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
